// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-requester sram access controller.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Active levels of the sram control pins (rd strobe is active-low).
  localparam logic WR_ACT = 1'b1;
  localparam logic RD_ACT = 1'b0;
  localparam logic CS_ACT = 1'b1;

  // Width of the phase down-counter: it is loaded with (phase - 1), so it
  // must hold values up to max(phase) - 1. Never narrower than one bit.
  function automatic int cnt_width(input int setup_cyc, input int strobe_cyc,
                                   input int hold_cyc);
    int m;
    m = setup_cyc;
    if (strobe_cyc > m) m = strobe_cyc;
    if (hold_cyc > m) m = hold_cyc;
    if (m < 2) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/sram_rr_arb.sv
// Two-way grant selection for the sram controller; SRAM_ARB_FIXED_PRIO_EN selects fixed priority (req0 wins).
// Latency: purely combinational, grant valid in the same cycle as valid.
// Backpressure: grant is forced to zero while enable is low (controller busy).
module sram_rr_arb
  import sram_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

`ifdef SRAM_ARB_FIXED_PRIO_EN
  // History is irrelevant when requester 0 always wins a conflict.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  // One-hot grant: a lone requester always wins; conflicts go to the requester that did not win last.
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
`ifdef SRAM_ARB_FIXED_PRIO_EN
        2'b11:   grant = 2'b01;
`else
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
`endif
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester controller for a single-port async sram: arbitrates, sequences setup/strobe/hold, returns responses.
// Latency: accept at A, rsp_valid at A+1+SETUP_CYC+STROBE_CYC+HOLD_CYC; optional SRAM_ARB_FIXED_PRIO_EN fixes priority.
// Backpressure: reqN_ready only in IDLE for the granted requester; one access in flight, no response backpressure.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rdata,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rdata,
  output logic          sram_cs,
  output logic          sram_wr,
  output logic          sram_rd,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_din,
  input  logic [DW-1:0] sram_dout,
  output logic          busy
);

  if (SETUP_CYC < 1 || STROBE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_phase
    $error("sram_arbiter: SETUP_CYC, STROBE_CYC and HOLD_CYC must all be >= 1");
  end

  localparam int CW = cnt_width(SETUP_CYC, STROBE_CYC, HOLD_CYC);
  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          cmd_we;
  logic          cmd_id;
  logic          last_grant;
  logic [DW-1:0] rd_q;
  logic [1:0]    grant;

  logic          acc_vld;
  logic          acc_id;
  logic          acc_we;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;

  sram_rr_arb u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .enable     (state == IDLE),
    .grant      (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  assign acc_vld   = |grant;
  assign acc_id    = grant[1];
  assign acc_we    = acc_id ? req1_we    : req0_we;
  assign acc_addr  = acc_id ? req1_addr  : req0_addr;
  assign acc_wdata = acc_id ? req1_wdata : req0_wdata;

  // Phase sequencer: every sram pin and response is registered; each phase runs its counter down to 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      cmd_we     <= 1'b0;
      cmd_id     <= 1'b0;
      last_grant <= 1'b1;
      rd_q       <= '0;
      sram_cs    <= ~CS_ACT;
      sram_wr    <= ~WR_ACT;
      sram_rd    <= ~RD_ACT;
      sram_addr  <= '0;
      sram_din   <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
      busy       <= 1'b0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (acc_vld) begin
            state      <= SETUP;
            cnt        <= SETUP_LD;
            cmd_we     <= acc_we;
            cmd_id     <= acc_id;
            last_grant <= acc_id;
            sram_cs    <= CS_ACT;
            sram_addr  <= acc_addr;
            sram_din   <= acc_we ? acc_wdata : '0;
            busy       <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state <= STROBE;
            cnt   <= STROBE_LD;
            if (cmd_we) sram_wr <= WR_ACT;
            else        sram_rd <= RD_ACT;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            state   <= HOLD;
            cnt     <= HOLD_LD;
            sram_wr <= ~WR_ACT;
            sram_rd <= ~RD_ACT;
            // Read data is sampled while the read strobe is still asserted.
            if (!cmd_we) rd_q <= sram_dout;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state   <= IDLE;
            sram_cs <= ~CS_ACT;
            busy    <= 1'b0;
            if (cmd_id) begin
              rsp1_valid <= 1'b1;
              if (!cmd_we) rsp1_rdata <= rd_q;
            end else begin
              rsp0_valid <= 1'b1;
              if (!cmd_we) rsp0_rdata <= rd_q;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: default-timing instance plus a stretched-timing instance.
// Latency: each scenario is cycle-exact against hand-derived schedules.
// Backpressure: requesters hold valid until ready, then drop or keep presenting as the scenario needs.
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  // Default-parameter instance signals.
  logic       req0_valid, req0_ready, req0_we;
  logic [7:0] req0_addr, req0_wdata;
  logic       req1_valid, req1_ready, req1_we;
  logic [7:0] req1_addr, req1_wdata;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_rdata, rsp1_rdata;
  logic       sram_cs, sram_wr, sram_rd, busy;
  logic [7:0] sram_addr, sram_din, sram_dout;

  // Stretched-timing instance signals.
  logic       p_req0_valid, p_req0_ready, p_req0_we;
  logic [7:0] p_req0_addr, p_req0_wdata;
  logic       p_req1_valid, p_req1_ready, p_req1_we;
  logic [7:0] p_req1_addr, p_req1_wdata;
  logic       p_rsp0_valid, p_rsp1_valid;
  logic [7:0] p_rsp0_rdata, p_rsp1_rdata;
  logic       p_sram_cs, p_sram_wr, p_sram_rd, p_busy;
  logic [7:0] p_sram_addr, p_sram_din, p_sram_dout;

  sram_arbiter u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .sram_cs(sram_cs), .sram_wr(sram_wr), .sram_rd(sram_rd),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout),
    .busy(busy)
  );

  sram_arbiter #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(p_req0_valid), .req0_ready(p_req0_ready), .req0_we(p_req0_we),
    .req0_addr(p_req0_addr), .req0_wdata(p_req0_wdata),
    .req1_valid(p_req1_valid), .req1_ready(p_req1_ready), .req1_we(p_req1_we),
    .req1_addr(p_req1_addr), .req1_wdata(p_req1_wdata),
    .rsp0_valid(p_rsp0_valid), .rsp0_rdata(p_rsp0_rdata),
    .rsp1_valid(p_rsp1_valid), .rsp1_rdata(p_rsp1_rdata),
    .sram_cs(p_sram_cs), .sram_wr(p_sram_wr), .sram_rd(p_sram_rd),
    .sram_addr(p_sram_addr), .sram_din(p_sram_din), .sram_dout(p_sram_dout),
    .busy(p_busy)
  );

  // Behavioural sram models: write while cs and wr are active, drive dout while cs and rd (active-low) are active.
  logic [7:0] mem  [256];
  logic [7:0] mem2 [256];
  assign sram_dout   = (sram_cs && !sram_rd) ? mem[sram_addr] : 8'h00;
  assign p_sram_dout = (p_sram_cs && !p_sram_rd) ? mem2[p_sram_addr] : 8'h00;

  always @(posedge clk) if (sram_cs && sram_wr) mem[sram_addr] <= sram_din;
  always @(posedge clk) if (p_sram_cs && p_sram_wr) mem2[p_sram_addr] <= p_sram_din;

  task automatic apply_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    p_req0_valid = 1'b0; p_req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = 8'h00; req0_wdata = 8'h00;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = 8'h00; req1_wdata = 8'h00;
    p_req0_valid = 1'b0; p_req0_we = 1'b0; p_req0_addr = 8'h00; p_req0_wdata = 8'h00;
    p_req1_valid = 1'b0; p_req1_we = 1'b0; p_req1_addr = 8'h00; p_req1_wdata = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({sram_cs, sram_wr, sram_rd} !== 3'b001) begin
      errors++; $display("FAIL reset_strobes got cs/wr/rd=%b expected 001", {sram_cs, sram_wr, sram_rd});
    end
    vectors++;
    if ({sram_addr, sram_din} !== 16'h0000) begin
      errors++; $display("FAIL reset_addr_din got %h/%h expected 00/00", sram_addr, sram_din);
    end
    vectors++;
    if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_rsp_busy got %b expected 000", {rsp0_valid, rsp1_valid, busy});
    end
    vectors++;
    if ({rsp0_rdata, rsp1_rdata} !== 16'h0000) begin
      errors++; $display("FAIL reset_rdata got %h/%h expected 00/00", rsp0_rdata, rsp1_rdata);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_write();
    logic e;
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 8'hAC; req0_wdata = 8'h5B;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      e = (c == 0);
      vectors++;
      if (req0_ready !== e) begin errors++; $display("FAIL wr_ready0 c=%0d got %b expected %b", c, req0_ready, e); end
      e = (c >= 1 && c <= 4);
      vectors++;
      if (sram_cs !== e) begin errors++; $display("FAIL wr_cs c=%0d got %b expected %b", c, sram_cs, e); end
      e = (c >= 2 && c <= 3);
      vectors++;
      if (sram_wr !== e) begin errors++; $display("FAIL wr_wr c=%0d got %b expected %b", c, sram_wr, e); end
      vectors++;
      if (sram_rd !== 1'b1) begin errors++; $display("FAIL wr_rd c=%0d got %b expected 1", c, sram_rd); end
      e = (c == 5);
      vectors++;
      if (rsp0_valid !== e) begin errors++; $display("FAIL wr_rsp0 c=%0d got %b expected %b", c, rsp0_valid, e); end
      if (c >= 1 && c <= 4) begin
        vectors++;
        if ({sram_addr, sram_din} !== 16'hAC5B) begin
          errors++; $display("FAIL wr_addr_din c=%0d got %h/%h expected AC/5B", c, sram_addr, sram_din);
        end
      end
      if (c == 5) begin
        vectors++;
        if (rsp0_rdata !== 8'h00) begin errors++; $display("FAIL wr_rdata_hold got %h expected 00", rsp0_rdata); end
      end
      @(posedge clk);
      #1;
      if (c == 0) req0_valid = 1'b0;
    end
  endtask

  task automatic test_read();
    logic e;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'hAC; req1_wdata = 8'hFF;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      e = (c == 0);
      vectors++;
      if ({req1_ready, req0_ready} !== {e, 1'b0}) begin
        errors++; $display("FAIL rd_ready c=%0d got r1r0=%b%b expected %b0", c, req1_ready, req0_ready, e);
      end
      e = !(c >= 2 && c <= 3);
      vectors++;
      if (sram_rd !== e) begin errors++; $display("FAIL rd_rd c=%0d got %b expected %b", c, sram_rd, e); end
      vectors++;
      if (sram_wr !== 1'b0) begin errors++; $display("FAIL rd_wr c=%0d got %b expected 0", c, sram_wr); end
      if (c >= 1 && c <= 4) begin
        vectors++;
        if ({sram_cs, sram_addr, sram_din} !== {1'b1, 16'hAC00}) begin
          errors++; $display("FAIL rd_cs_addr_din c=%0d got %b/%h/%h expected 1/AC/00", c, sram_cs, sram_addr, sram_din);
        end
      end
      e = (c == 5);
      vectors++;
      if (rsp1_valid !== e) begin errors++; $display("FAIL rd_rsp1 c=%0d got %b expected %b", c, rsp1_valid, e); end
      if (c == 5) begin
        vectors++;
        if (rsp1_rdata !== 8'h5B) begin errors++; $display("FAIL rd_rdata got %h expected 5B", rsp1_rdata); end
      end
      @(posedge clk);
      #1;
      if (c == 0) req1_valid = 1'b0;
    end
  endtask

  task automatic test_conflict();
    logic e0, e1;
    apply_reset();
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 8'h10; req0_wdata = 8'h11;
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 8'h20; req1_wdata = 8'h22;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
`ifdef SRAM_ARB_FIXED_PRIO_EN
      e0 = (c % 5 == 0);
      e1 = 1'b0;
`else
      e0 = (c % 5 == 0) && ((c / 5) % 2 == 0);
      e1 = (c % 5 == 0) && ((c / 5) % 2 == 1);
`endif
      vectors++;
      if ({req0_ready, req1_ready} !== {e0, e1}) begin
        errors++; $display("FAIL conflict_grant c=%0d got r0r1=%b%b expected %b%b", c, req0_ready, req1_ready, e0, e1);
      end
      if (c == 5) begin
        vectors++;
        if (rsp0_valid !== 1'b1) begin errors++; $display("FAIL conflict_rsp0 c=5 got %b expected 1", rsp0_valid); end
      end
      @(posedge clk);
      #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (mem[8'h10] !== 8'h11) begin errors++; $display("FAIL conflict_mem10 got %h expected 11", mem[8'h10]); end
`ifndef SRAM_ARB_FIXED_PRIO_EN
    vectors++;
    if (mem[8'h20] !== 8'h22) begin errors++; $display("FAIL conflict_mem20 got %h expected 22", mem[8'h20]); end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midop();
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 8'h33; req0_wdata = 8'h44;
    @(negedge clk);
    vectors++;
    if (req0_ready !== 1'b1) begin errors++; $display("FAIL midop_ready0 got %b expected 1", req0_ready); end
    @(posedge clk); #1 req0_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (sram_wr !== 1'b1) begin errors++; $display("FAIL midop_in_strobe got wr=%b expected 1", sram_wr); end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if ({sram_wr, sram_cs, busy, sram_rd} !== 4'b0001) begin
      errors++; $display("FAIL midop_after_reset got wr/cs/busy/rd=%b expected 0001", {sram_wr, sram_cs, busy, sram_rd});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      vectors++;
      if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
        errors++; $display("FAIL midop_no_rsp c=%0d got rsp0/rsp1/busy=%b expected 000", c, {rsp0_valid, rsp1_valid, busy});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_params();
    logic e;
    p_req0_valid = 1'b1; p_req0_we = 1'b1; p_req0_addr = 8'h01; p_req0_wdata = 8'h77;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      e = (c == 0);
      vectors++;
      if (p_req0_ready !== e) begin errors++; $display("FAIL p_wr_ready0 c=%0d got %b expected %b", c, p_req0_ready, e); end
      e = (c >= 1 && c <= 6);
      vectors++;
      if (p_sram_cs !== e) begin errors++; $display("FAIL p_wr_cs c=%0d got %b expected %b", c, p_sram_cs, e); end
      e = (c >= 3 && c <= 5);
      vectors++;
      if (p_sram_wr !== e) begin errors++; $display("FAIL p_wr_wr c=%0d got %b expected %b", c, p_sram_wr, e); end
      e = (c == 7);
      vectors++;
      if (p_rsp0_valid !== e) begin errors++; $display("FAIL p_wr_rsp0 c=%0d got %b expected %b", c, p_rsp0_valid, e); end
      @(posedge clk); #1;
      if (c == 0) p_req0_valid = 1'b0;
    end
    p_req1_valid = 1'b1; p_req1_we = 1'b0; p_req1_addr = 8'h01; p_req1_wdata = 8'h00;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      e = (c == 0);
      vectors++;
      if (p_req1_ready !== e) begin errors++; $display("FAIL p_rd_ready1 c=%0d got %b expected %b", c, p_req1_ready, e); end
      e = !(c >= 3 && c <= 5);
      vectors++;
      if (p_sram_rd !== e) begin errors++; $display("FAIL p_rd_rd c=%0d got %b expected %b", c, p_sram_rd, e); end
      e = (c == 7);
      vectors++;
      if (p_rsp1_valid !== e) begin errors++; $display("FAIL p_rd_rsp1 c=%0d got %b expected %b", c, p_rsp1_valid, e); end
      if (c == 7) begin
        vectors++;
        if (p_rsp1_rdata !== 8'h77) begin errors++; $display("FAIL p_rd_rdata got %h expected 77", p_rsp1_rdata); end
      end
      @(posedge clk); #1;
      if (c == 0) p_req1_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_conflict();
    test_reset_midop();
    test_params();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
